// File: rtl/pingpong_sample_ram.sv
// pingpong_sample_ram
// Double-buffered sample memory between the ADC capture stream and the FFT.
// One bank fills from an unstallable sample stream while the other, complete
// bank is read through two independent registered read ports.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   wr_valid/wr_data sample stream (cannot be stalled)
//   addr_a/addr_b    read addresses into the current read bank
//   q_a/q_b          registered read data
//   rd_done          consumer pulse: release the current read bank
//   frame_ready      a complete frame sits in rd_bank
//   rd_bank/wr_bank  bank presented to readers / bank being filled
//   overflow         sticky: at least one sample was dropped
//
// Build option: define PINGPONG_SAMPLE_RAM_OUTREG_EN to add a second output
// register on q_a/q_b (read latency 2 instead of 1).
//
// Write FSM:
//   state  | meaning
//   W_FILL | samples are written into wr_bank
//   W_WAIT | both banks full; incoming samples are dropped

module pingpong_sample_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  input  logic              rd_done,
  output logic              frame_ready,
  output logic              rd_bank,
  output logic              wr_bank,
  output logic              overflow
);

  typedef enum logic {W_FILL, W_WAIT} wstate_e;

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(FRAME_LEN - 1);

  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  wstate_e           state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              wr_en;
  logic              rd_release;
  logic [DATA_W-1:0] q_a_q, q_b_q;

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_cnt_d   = wr_cnt_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    rd_release = rd_done && full_q[rd_bank_q];

    // Apply the release first so a frame completing in the same cycle sees
    // the freed bank and can hand off without a drop.
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    case (state_q)
      W_FILL: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_CNT) begin
            wr_cnt_d          = '0;
            full_d[wr_bank_q] = 1'b1;
            if (!full_d[~wr_bank_q]) wr_bank_d = ~wr_bank_q;
            else                     state_d   = W_WAIT;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      W_WAIT: begin
        if (wr_valid) overflow_d = 1'b1;
        // A sample coinciding with the releasing rd_done is still dropped.
        if (!full_d[~wr_bank_q]) begin
          wr_bank_d = ~wr_bank_q;
          state_d   = W_FILL;
        end
      end
      default: state_d = W_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= W_FILL;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never reset; the bank bit is the address MSB.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[{wr_bank_q, wr_cnt_q}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= mem[{rd_bank_q, addr_a}];
      q_b_q <= mem[{rd_bank_q, addr_b}];
    end
  end

`ifdef PINGPONG_SAMPLE_RAM_OUTREG_EN
  logic [DATA_W-1:0] q_a2_q, q_b2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_a2_q <= '0;
      q_b2_q <= '0;
    end else begin
      q_a2_q <= q_a_q;
      q_b2_q <= q_b_q;
    end
  end

  assign q_a = q_a2_q;
  assign q_b = q_b2_q;
`else
  assign q_a = q_a_q;
  assign q_b = q_b_q;
`endif

  assign frame_ready = full_q[rd_bank_q];
  assign rd_bank     = rd_bank_q;
  assign wr_bank     = wr_bank_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pingpong_sample_ram.sv
module tb_pingpong_sample_ram;

`ifdef PINGPONG_SAMPLE_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic [9:0] addr_a, addr_b;
  logic [7:0] q_a, q_b;
  logic       rd_done;
  logic       frame_ready, rd_bank, wr_bank, overflow;

  int n_assert = 0;
  int n_fail   = 0;

  pingpong_sample_ram #(.DATA_W(8), .ADDR_W(10), .FRAME_LEN(1024)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .addr_a(addr_a), .addr_b(addr_b), .q_a(q_a), .q_b(q_b),
    .rd_done(rd_done), .frame_ready(frame_ready), .rd_bank(rd_bank),
    .wr_bank(wr_bank), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [9:0] b,
                    input logic [7:0] ea, input logic [7:0] eb);
    addr_a = a;
    addr_b = b;
    repeat (LAT) tick();
    chk({tag, "_qa"}, q_a, ea);
    chk({tag, "_qb"}, q_b, eb);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, frame_ready, 1'b0);
    chk({tag, "_rdbank"}, rd_bank, 1'b0);
    chk({tag, "_wrbank"}, wr_bank, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_qa"}, q_a, 8'h00);
    chk({tag, "_qb"}, q_b, 8'h00);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
    addr_a = '0; addr_b = '0; rd_done = 1'b0;

    // Reset state
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;

    // Fill frame 0 with i[7:0]
    for (int i = 0; i < 1024; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      tick();
      if (i == 1022) chk("fill_ready_early", frame_ready, 1'b0);
    end
    wr_valid = 1'b0;
    chk("fill_ready", frame_ready, 1'b1);
    chk("fill_rdbank", rd_bank, 1'b0);
    chk("fill_wrbank", wr_bank, 1'b1);
    for (int j = 0; j < 1024; j += 2)
      rd("sweep", 10'(j), 10'(j + 1), 8'(j), 8'(j + 1));

    // Frame 1 (~i) into bank 1 while bank 0 still held, then release
    for (int i = 0; i < 1024; i++) begin
      wr_valid = 1'b1; wr_data = ~8'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("pp_ready_before", frame_ready, 1'b1);
    chk("pp_rdbank_before", rd_bank, 1'b0);
    chk("pp_ovf_before", overflow, 1'b0);
    rd("pp_bank0", 10'd10, 10'd10, 8'd10, 8'd10);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("pp_rdbank", rd_bank, 1'b1);
    chk("pp_ready", frame_ready, 1'b1);
    chk("pp_wrbank", wr_bank, 1'b0);
    chk("pp_ovf", overflow, 1'b0);
    rd("pp_ends", 10'd0, 10'd1023, 8'hFF, 8'h00);
    rd("pp_same", 10'd5, 10'd5, 8'hFA, 8'hFA);

    // Last sample of frame 2 coincides with rd_done on bank 1
    for (int i = 0; i < 1024; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 7);
      rd_done = (i == 1023);
      tick();
    end
    wr_valid = 1'b0; rd_done = 1'b0;
    chk("sim_rdbank", rd_bank, 1'b0);
    chk("sim_wrbank", wr_bank, 1'b1);
    chk("sim_ready", frame_ready, 1'b1);
    chk("sim_ovf", overflow, 1'b0);
    rd("sim_ends", 10'd0, 10'd1023, 8'h07, 8'h06);

    // Release bank 0, then a stray rd_done with nothing ready
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("rel_rdbank", rd_bank, 1'b1);
    chk("rel_ready", frame_ready, 1'b0);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("stray_rdbank", rd_bank, 1'b1);
    chk("stray_ready", frame_ready, 1'b0);
    chk("stray_wrbank", wr_bank, 1'b1);

    // Reset in the middle of a frame
    for (int i = 0; i < 300; i++) begin
      wr_valid = 1'b1; wr_data = 8'hCC;
      tick();
    end
    wr_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("midrst");

    // A full new frame is needed before frame_ready
    for (int i = 0; i < 1024; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i) ^ 8'hA5;
      tick();
      if (i == 1022) chk("postrst_ready_early", frame_ready, 1'b0);
    end
    wr_valid = 1'b0;
    chk("postrst_ready", frame_ready, 1'b1);
    chk("postrst_rdbank", rd_bank, 1'b0);
    chk("postrst_wrbank", wr_bank, 1'b1);
    rd("postrst_data", 10'd0, 10'd299, 8'hA5, 8'h8E);

    // Second frame fills bank 1 -> both full; further samples overflow
    for (int i = 0; i < 1024; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    chk("ovf_before", overflow, 1'b0);
    wr_data = 8'hEE;
    tick();
    chk("ovf_first_drop", overflow, 1'b1);
    repeat (4) tick();
    rd_done = 1'b1; tick();
    rd_done = 1'b0; wr_valid = 1'b0;
    chk("ovf_rdbank", rd_bank, 1'b1);
    chk("ovf_ready", frame_ready, 1'b1);
    chk("ovf_wrbank", wr_bank, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    rd("ovf_bank1", 10'd0, 10'd1023, 8'h01, 8'h00);

    // Next frame lands in bank 0 from address 0
    for (int i = 0; i < 1024; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i) ^ 8'h0F;
      tick();
    end
    wr_valid = 1'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("after_rdbank", rd_bank, 1'b0);
    chk("after_ready", frame_ready, 1'b1);
    chk("after_wrbank", wr_bank, 1'b1);
    chk("after_ovf", overflow, 1'b1);
    rd("after_ends", 10'd0, 10'd1023, 8'h0F, 8'hF0);
    rd("after_same", 10'd1, 10'd1, 8'h0E, 8'h0E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
